// File: rtl/rx_os_assembler_pkg.sv
// Shared symbol constants, lane state encoding and helpers for the ordered-set assembler.
package rx_os_assembler_pkg;

    localparam int unsigned NUM_LANES = 16;

    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] PAD      = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h4A;
    localparam logic [7:0] TS2_ID   = 8'h45;
    localparam logic [7:0] GEN3_TS1 = 8'h1E;
    localparam logic [7:0] GEN3_TS2 = 8'h2D;
    localparam logic [1:0] SH_OS    = 2'b01;

    typedef enum logic [1:0] {
        LANE_IDLE,
        LANE_CAPTURE,
        LANE_DONE
    } lane_state_t;

    // Detected-lane count to lane mask; 0 means x1, anything above 16 means x16.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [4:0] n);
        int unsigned cnt;
        logic [NUM_LANES-1:0] m;
        cnt = int'(n);
        if (cnt == 0) cnt = 1;
        if (cnt > NUM_LANES) cnt = NUM_LANES;
        m = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            m[i] = (i < cnt);
        end
        return m;
    endfunction

    // TS1/TS2 identifier check: symbol 6 is the identifier and symbols 7..15 repeat it.
    // Symbol 15 is passed separately since it is being sampled in the same cycle.
    function automatic logic ts_check(input logic [127:0] os, input logic [7:0] last);
        logic [7:0] id;
        logic       ok;
        id = os[55:48];
        ok = (id == TS1_ID) || (id == TS2_ID);
        for (int unsigned i = 7; i < 15; i++) begin
            if (os[8*i +: 8] != id) ok = 1'b0;
        end
        if (last != id) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/os_lane_assembler.sv
// One lane of the ordered-set assembler: detects a TS start, collects 16 symbols,
// validates them and holds the set in DONE until the top level releases or flushes it.
module os_lane_assembler (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   gen,
    input  logic         gen_changed,
    input  logic         active,
    input  logic [7:0]   sym,
    input  logic         k,
    input  logic         valid,
    input  logic         start_block,
    input  logic [1:0]   sync_hdr,
    input  logic         clear,
    output logic         done,
    output logic [127:0] os_data
);
    import rx_os_assembler_pkg::*;

    lane_state_t  state;
    logic [3:0]   idx;
    logic [127:0] buffer;

    logic gen12, gen3, start, is_com, bad_k, early_block;

    always_comb begin
        gen12       = (gen == 3'd1) || (gen == 3'd2);
        gen3        = (gen == 3'd3);
        is_com      = gen12 && k && (sym == COM);
        start       = valid && (is_com ||
                      (gen3 && start_block && (sync_hdr == SH_OS) &&
                       ((sym == GEN3_TS1) || (sym == GEN3_TS2))));
        bad_k       = gen12 && k && (idx >= 4'd3) && (sym != PAD);
        early_block = gen3 && start_block && (idx != 4'd15);
    end

    assign done    = (state == LANE_DONE);
    assign os_data = buffer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LANE_IDLE;
            idx    <= '0;
            buffer <= '0;
        end else if (!active || !(gen12 || gen3)) begin
            state <= LANE_IDLE;
        end else begin
            case (state)
                LANE_IDLE: begin
                    if (start) begin
                        buffer[7:0] <= sym;
                        idx         <= 4'd1;
                        state       <= LANE_CAPTURE;
                    end
                end
                LANE_CAPTURE: begin
                    if (gen_changed || early_block) begin
                        state <= LANE_IDLE;
                    end else if (valid) begin
                        // A COM mid-set restarts capture in place rather than dropping to IDLE.
                        if (is_com) begin
                            buffer[7:0] <= sym;
                            idx         <= 4'd1;
                        end else if (bad_k) begin
                            state <= LANE_IDLE;
                        end else begin
                            buffer[{idx, 3'b000} +: 8] <= sym;
                            if (idx == 4'd15) begin
                                state <= (gen3 || ts_check(buffer, sym)) ? LANE_DONE : LANE_IDLE;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                LANE_DONE: begin
                    if (clear) state <= LANE_IDLE;
                end
                default: state <= LANE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rx_os_assembler.sv
// Aligns per-lane TS1/TS2 captures into one 16-lane bundle, releasing when every
// active lane is complete and flushing on skew-window expiry.
module rx_os_assembler #(
    parameter int MAX_SKEW = 4,
    parameter int LANES    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            Gen,
    input  logic [4:0]            numberOfDetectedLanes,
    input  logic [8*LANES-1:0]    rxData,
    input  logic [LANES-1:0]      rxDataK,
    input  logic [LANES-1:0]      rxValid,
    input  logic [LANES-1:0]      rxStartBlock,
    input  logic [2*LANES-1:0]    rxSyncHeader,
    output logic [128*LANES-1:0]  orderedSets,
    output logic                  validOrderedSets,
    output logic                  skewError
);
    import rx_os_assembler_pkg::*;

    localparam int unsigned SKEW_W = $clog2(MAX_SKEW + 1);

    logic [LANES-1:0]  active;
    logic [LANES-1:0]  done;
    logic [127:0]      lane_os [LANES];
    logic [2:0]        gen_q;
    logic [SKEW_W-1:0] skew_cnt;

    logic gen_changed, all_done, any_done, skew_hit, clear_done;

    always_comb begin
        gen_changed = (Gen != gen_q);
        all_done    = (active != '0) && ((done & active) == active);
        any_done    = |(done & active);
        skew_hit    = any_done && !all_done && (skew_cnt == SKEW_W'(MAX_SKEW - 1));
        clear_done  = all_done || skew_hit;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        os_lane_assembler u_lane (
            .clk         (clk),
            .reset       (reset),
            .gen         (Gen),
            .gen_changed (gen_changed),
            .active      (active[g]),
            .sym         (rxData[8*g +: 8]),
            .k           (rxDataK[g]),
            .valid       (rxValid[g]),
            .start_block (rxStartBlock[g]),
            .sync_hdr    (rxSyncHeader[2*g +: 2]),
            .clear       (clear_done),
            .done        (done[g]),
            .os_data     (lane_os[g])
        );
    end

    // Lane mask is registered so a lane-count change applies from the next cycle's evaluation.
    always_ff @(posedge clk) begin
        if (reset) begin
            active           <= '0;
            gen_q            <= '0;
            skew_cnt         <= '0;
            orderedSets      <= '0;
            validOrderedSets <= 1'b0;
            skewError        <= 1'b0;
        end else begin
            active           <= lane_mask(numberOfDetectedLanes);
            gen_q            <= Gen;
            validOrderedSets <= all_done;
            skewError        <= skew_hit;
            if (all_done) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    orderedSets[128*i +: 128] <= active[i] ? lane_os[i] : '0;
                end
                skew_cnt <= '0;
            end else if (skew_hit || !any_done) begin
                skew_cnt <= '0;
            end else begin
                skew_cnt <= skew_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/rx_os_assembler.md
# rx_os_assembler

Per-lane receive front end that turns raw PIPE receive symbols into complete 16-symbol TS1/TS2 ordered sets. It delivers them as a 16-lane, 2048-bit bundle with a single-cycle valid strobe. It sits directly upstream of the receive LTSSM, which consumes `orderedSets`/`validOrderedSets`. Lanes are aligned by waiting until every active lane holds a complete ordered set, bounded by a skew window.

## Interface
Parameters:
- `MAX_SKEW`, default 4: cycles allowed between the first and last active lane completing an ordered set.
- `LANES`, default 16: lane count; fixed at 16 for this release.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `Gen`, in, 3: 1 and 2 select 8b/10b framing; 3 selects 128b/130b framing. Other values hold all lanes in IDLE.
- `numberOfDetectedLanes`, in, 5: active lanes 0..N-1. Value 0 is treated as 1; values above 16 are treated as 16.
- `rxData`, in, 128: lane i symbol at [8i+7:8i], one symbol per lane per cycle.
- `rxDataK`, in, 16: K-symbol flag per lane (Gen1/2 only).
- `rxValid`, in, 16: symbol valid per lane.
- `rxStartBlock`, in, 16: first symbol of a 128b/130b block (Gen3).
- `rxSyncHeader`, in, 32: lane i sync header at [2i+1:2i]; sampled with `rxStartBlock`.
- `orderedSets`, out, 2048: lane i ordered set at [128i+127:128i], symbol 0 at bits [7:0].
- `validOrderedSets`, out, 1: one-cycle strobe; `orderedSets` is valid this cycle.
- `skewError`, out, 1: one-cycle pulse when the skew window expires.

## Operation
- Per-lane FSM with states IDLE, CAPTURE and DONE.
- IDLE → CAPTURE, Gen1/2: `rxValid` & `rxDataK` & symbol == COM (BC). The COM is stored as symbol 0.
- IDLE → CAPTURE, Gen3: `rxValid` & `rxStartBlock` & sync header == 01 & symbol ∈ {1E, 2D}. The identifier is stored as symbol 0.
- CAPTURE: store one symbol per valid cycle into an index 1..15 counter. Cycles without `rxValid` are stalls, not aborts.
- CAPTURE aborts to IDLE when any of these occurs:
  - Gen1/2: a K symbol arrives at index ≥ 3 other than PAD (F7).
  - Gen1/2: COM arrives at any index; this restarts the capture at symbol 0 instead of returning to IDLE.
  - Gen3: `rxStartBlock` is asserted before index 15.
  - `Gen` changes.
- At index 15 (Gen1/2), symbol 6 must be 4A (TS1) or 45 (TS2), and symbols 7..15 must equal symbol 6. On pass → DONE; on fail → IDLE.
- At index 15 (Gen3), the lane goes → DONE with no further checks.
- DONE: the lane holds its 128-bit buffer and ignores new starts until it is released.
- Inactive lanes (i ≥ active count) stay in IDLE and their `orderedSets` slice reads 0.
- Release and skew handling:
  - When every active lane is in DONE, the block copies all buffers to `orderedSets`, pulses `validOrderedSets`, and returns all lanes to IDLE.
  - A skew counter starts the cycle the first active lane enters DONE.
  - If the counter reaches `MAX_SKEW` before all active lanes are DONE, every DONE lane is flushed to IDLE, `skewError` pulses and the counter clears.
  - If the last lane completes in the same cycle the counter reaches `MAX_SKEW`, release wins and there is no error.
- `orderedSets` holds its value between strobes.

## Timing
- Reset values: all lanes IDLE, `orderedSets` = 0, `validOrderedSets` = 0, `skewError` = 0, skew counter = 0.
- Reset asserted mid-capture discards all partial and DONE state on the next edge.
- The lane enters DONE one cycle after its symbol 15 is sampled.
- `validOrderedSets` asserts one cycle after the last active lane enters DONE. With aligned lanes this is 2 cycles after symbol 15 is sampled.
- A lane released at cycle N may start a new capture from its symbol at cycle N+1. A start symbol presented at cycle N is dropped.
- A `numberOfDetectedLanes` change takes effect in the next cycle's all-DONE evaluation.

## Structure
- Shared package constants: COM, PAD, TS1_ID, TS2_ID, GEN3_TS1, GEN3_TS2, SH_OS, and the lane state encoding.
- Sub-module `os_lane_assembler` contains one lane's FSM, index counter, 128-bit buffer and checks. It is instantiated 16 times in a generate loop.
- The top level holds the active-lane mask, the all-DONE reduction, the skew counter and the output register.

## Test plan
- x4 Gen1, aligned TS1 on lanes 0..3 (COM, link 00, lane i, …, symbols 6..15 = 4A) → one `validOrderedSets` 2 cycles after symbol 15. `orderedSets[7:0]` = BC, `orderedSets[55:48]` = 4A, and lanes 4..15 read 0.
- x2 Gen1, lane 1 delayed 3 cycles with `MAX_SKEW`=4 → valid with both lanes. Lane 1 delayed 4 cycles → `skewError` pulse, no valid, and lane 1's set is discarded.
- Gen2 TS2 with symbol 9 = 4A → lane returns to IDLE and no valid is produced. A COM at index 8 restarts the capture, and the next clean TS2 produces valid.
- Gen3 x1, `rxStartBlock` with sync 01, symbol 2D, 16 symbols with 2 stall cycles inserted → valid carries 2D at [7:0]. Sync 10 with symbol 1E → ignored.
- Reset pulsed while 3 of 4 lanes are DONE → no valid and all outputs 0. A following aligned set is captured normally.
